// File: rtl/serial_tx.sv
// Asynchronous serial transmitter: start bit, WIDTH data bits LSB first, optional even parity, stop bit.
// Define SERIAL_TX_PARITY_EN to build the PARITY state and even-parity bit.
module serial_tx #(
    parameter int DIV   = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data,
    input  logic             valid,
    output logic             ready,
    output logic             txd,
    output logic             busy,
    output logic [2:0]       dbg_state
);

    // Handshake: a word is taken on a rising edge where valid=1 and ready=1;
    // ready is high only in IDLE, so valid/data are ignored for the whole frame.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd3
`ifdef SERIAL_TX_PARITY_EN
        , PARITY = 3'd4
`endif
    } state_t;

    localparam logic [15:0] RELOAD = 16'(DIV - 1);
    localparam logic [3:0]  LAST   = 4'(WIDTH - 1);

    state_t           state, state_n;
    logic [15:0]      cnt, cnt_n;
    logic [3:0]       idx, idx_n;
    logic [WIDTH-1:0] sh, sh_n;
    logic             txd_q, txd_n;
`ifdef SERIAL_TX_PARITY_EN
    logic             par, par_n;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            sh    <= '0;
            txd_q <= 1'b1;
`ifdef SERIAL_TX_PARITY_EN
            par   <= 1'b0;
`endif
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
            sh    <= sh_n;
            txd_q <= txd_n;
`ifdef SERIAL_TX_PARITY_EN
            par   <= par_n;
`endif
        end
    end

    // Every transition computes the line level for the next bit, so txd is a plain flop.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        sh_n    = sh;
        txd_n   = txd_q;
`ifdef SERIAL_TX_PARITY_EN
        par_n   = par;
`endif
        case (state)
            IDLE: begin
                if (valid) begin
                    state_n = START;
                    cnt_n   = RELOAD;
                    idx_n   = '0;
                    sh_n    = data;
                    txd_n   = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
                    par_n   = ^data;
`endif
                end
            end
            START: begin
                if (cnt == 16'd0) begin
                    state_n = DATA;
                    cnt_n   = RELOAD;
                    txd_n   = sh[0];
                end else begin
                    cnt_n = cnt - 16'd1;
                end
            end
            DATA: begin
                if (cnt != 16'd0) begin
                    cnt_n = cnt - 16'd1;
                end else begin
                    cnt_n = RELOAD;
                    if (idx == LAST) begin
`ifdef SERIAL_TX_PARITY_EN
                        state_n = PARITY;
                        txd_n   = par;
`else
                        state_n = STOP;
                        txd_n   = 1'b1;
`endif
                    end else begin
                        idx_n = idx + 4'd1;
                        sh_n  = sh >> 1;
                        txd_n = sh[1];
                    end
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            PARITY: begin
                if (cnt == 16'd0) begin
                    state_n = STOP;
                    cnt_n   = RELOAD;
                    txd_n   = 1'b1;
                end else begin
                    cnt_n = cnt - 16'd1;
                end
            end
`endif
            STOP: begin
                if (cnt == 16'd0) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    idx_n   = '0;
                    txd_n   = 1'b1;
                end else begin
                    cnt_n = cnt - 16'd1;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
                idx_n   = '0;
                txd_n   = 1'b1;
            end
        endcase
    end

    assign ready     = (state == IDLE);
    assign busy      = ~ready;
    assign txd       = txd_q;
    assign dbg_state = state;

endmodule

// File: doc/serial_tx.md
SERIAL_TX -- requirements
Module: serial_tx

Interface
REQ-001 Parameter DIV, default 4: clock cycles per serial bit; legal range 1..65535.
REQ-002 Parameter WIDTH, default 8: data bits per frame; legal range 5..9.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 data  input  WIDTH  word to transmit; sampled only on acceptance.
REQ-006 valid  input  1  data is offered this cycle.
REQ-007 ready  output  1  block can accept a word this cycle.
REQ-008 txd  output  1  serial line; idle level 1.
REQ-009 busy  output  1  frame in progress; exact complement of ready.

Function
REQ-010 Acceptance SHALL occur on a rising edge where valid=1 and ready=1; data is latched into a shift register at that edge.
REQ-011 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP, with transitions IDLE->START on acceptance, START->DATA, DATA->PARITY (parity built) or DATA->STOP, PARITY->STOP, and STOP->IDLE.
REQ-012 Each of START, PARITY and STOP SHALL hold for exactly DIV cycles, and DATA SHALL hold for WIDTH*DIV cycles using a bit-period counter and a bit index.
REQ-013 txd SHALL be a registered output: 0 in START, shift-register bit 0 in DATA (LSB first, one bit per DIV cycles), the parity bit in PARITY, and 1 in STOP and IDLE.
REQ-014 txd SHALL first go low on the edge that accepts the word, giving a latency of 0 cycles after the acceptance edge.
REQ-015 ready SHALL go low on the acceptance edge and return high on the edge that ends STOP.
REQ-016 Frame length SHALL be (WIDTH+2)*DIV cycles, or (WIDTH+3)*DIV cycles with parity.
REQ-017 valid and data SHALL be ignored while ready=0, and a held word SHALL NOT be transmitted twice unless valid remains 1 after ready returns.
REQ-018 Back-to-back frames: when valid=1 in the first IDLE cycle, the next START SHALL begin with no extra idle cycle beyond that single IDLE cycle.
REQ-019 DIV=1 SHALL produce one cycle per bit with no counter underflow or wrap.
REQ-020 The bit-period counter SHALL reload to DIV-1 at every bit boundary and never wrap through zero.

Reset
REQ-021 While rst=1 the outputs SHALL be: txd=1, ready=1, busy=0; the state SHALL be IDLE and the counters 0. These values SHALL take effect immediately, without waiting for a clock edge.
REQ-022 Reset mid-frame SHALL abort the frame, with txd=1 immediately; the aborted word SHALL NOT be resumed.
REQ-023 The first acceptance after reset deasserts SHALL be possible on the first rising edge with rst=0.

Configuration
REQ-024 Macro SERIAL_TX_PARITY_EN defined: the PARITY state SHALL exist and transmit even parity, i.e. the XOR of all WIDTH data bits.
REQ-025 Macro SERIAL_TX_PARITY_EN undefined: the PARITY state and parity logic SHALL be absent, and DATA SHALL go directly to STOP.

Verification
REQ-026 DIV=4, no parity, send 8'hA5 -> txd = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; ready low for exactly 40 cycles.
REQ-027 DIV=4, valid held high with 8'h00 then 8'hFF -> two contiguous frames separated by one IDLE cycle; second frame's data bits are all 1.
REQ-028 Parity built, DIV=2, send 8'h07 -> parity bit 1; send 8'h0F -> parity bit 0; frame length 22 cycles.
REQ-029 DIV=4, assert rst 13 cycles into an 8'h3C frame -> txd=1 and ready=1 before the next edge; the next frame 8'h81 is correct.
REQ-030 DIV=1, pulse valid with 8'h55 while busy -> word ignored; the in-flight frame is unchanged and lasts 10 cycles.
